// File: rtl/jk_seq_ctrl.sv
// rtl/jk_seq_ctrl.sv - JK flip-flop bank sequencing controller
//
// Takes one command at a time over a valid/ready handshake. It then drives
// per-bit J/K for a programmed number of steps to load, clear, set, count
// modulo-MOD or shift an internal bank of WIDTH JK flip-flops.
//
// Ports:
//   C          clock, rising edge
//   CLR_       asynchronous active-low reset
//   cmd_valid  command present
//   cmd_ready  high only when idle; command accepted on valid&ready edge
//   cmd_op     000 NOP, 001 LOAD, 010 CLEAR, 011 SET,
//              100 UP, 101 DOWN, 110 SHL, 111 SHR
//   cmd_data   LOAD value / serial-in source for shifts
//   cmd_n      step count for NOP/UP/DOWN/SHL/SHR
//   Q, Q_      bank state and its complement
//   J_o, K_o   J/K drive applied at the current edge
//   busy       high in EXEC or DONE
//   done       one-cycle pulse in DONE
//   wrap       sticky per command: counter wrapped at least once
module jk_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int MOD   = 10,
  parameter int CNTW  = 8
) (
  input  logic             C,
  input  logic             CLR_,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNTW-1:0]  cmd_n,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_,
  output logic [WIDTH-1:0] J_o,
  output logic [WIDTH-1:0] K_o,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_LOAD  = 3'd1,
    OP_CLEAR = 3'd2,
    OP_SET   = 3'd3,
    OP_UP    = 3'd4,
    OP_DOWN  = 3'd5,
    OP_SHL   = 3'd6,
    OP_SHR   = 3'd7
  } op_t;

  // One bit wider than Q so MOD = 2^WIDTH still fits.
  localparam logic [WIDTH:0] MOD_M1 = (WIDTH+1)'(MOD - 1);

  state_t             state_q, state_d;
  op_t                op_q, op_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [CNTW-1:0]    rem_q, rem_d;
  logic               wrap_q, wrap_d;
  logic [WIDTH-1:0]   bank_q, bank_d;

  logic [WIDTH-1:0]   nxt;
  logic               wrap_step;
  logic [WIDTH-1:0]   j_drv, k_drv;

  // Target value of the bank after one step of the latched op.
  always_comb begin
    nxt       = bank_q;
    wrap_step = 1'b0;
    unique case (op_q)
      OP_NOP:   nxt = bank_q;
      OP_LOAD:  nxt = data_q;
      OP_CLEAR: nxt = '0;
      OP_SET:   nxt = '1;
      OP_UP: begin
        // >= rather than == so an out-of-range LOAD value wraps too.
        if ({1'b0, bank_q} >= MOD_M1) begin
          nxt       = '0;
          wrap_step = 1'b1;
        end else begin
          nxt = bank_q + WIDTH'(1);
        end
      end
      OP_DOWN: begin
        if (bank_q == '0) begin
          nxt       = MOD_M1[WIDTH-1:0];
          wrap_step = 1'b1;
        end else begin
          nxt = bank_q - WIDTH'(1);
        end
      end
      OP_SHL:   nxt = {bank_q[WIDTH-2:0], data_q[0]};
      OP_SHR:   nxt = {data_q[WIDTH-1], bank_q[WIDTH-1:1]};
      default:  nxt = bank_q;
    endcase
  end

  // Control FSM: next state, latched command fields and J/K drive.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    rem_d   = rem_q;
    wrap_d  = wrap_q;
    j_drv   = '0;
    k_drv   = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d   = op_t'(cmd_op);
          data_d = cmd_data;
          wrap_d = 1'b0;
          if (cmd_op == OP_LOAD || cmd_op == OP_CLEAR || cmd_op == OP_SET) begin
            rem_d   = CNTW'(1);
            state_d = ST_EXEC;
          end else if (cmd_n == '0) begin
            rem_d   = '0;
            state_d = ST_DONE;
          end else begin
            rem_d   = cmd_n;
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        // Toggle exactly the bits that must change; J=K=0 holds the rest.
        j_drv  = bank_q ^ nxt;
        k_drv  = bank_q ^ nxt;
        rem_d  = rem_q - CNTW'(1);
        wrap_d = wrap_q | wrap_step;
        if (rem_q == CNTW'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // JK flip-flop bank: driven only from J/K, never from nxt directly.
  always_comb begin
    bank_d = bank_q;
    for (int i = 0; i < WIDTH; i++) begin
      unique case ({j_drv[i], k_drv[i]})
        2'b11:   bank_d[i] = ~bank_q[i];
        2'b10:   bank_d[i] = 1'b1;
        2'b01:   bank_d[i] = 1'b0;
        default: bank_d[i] = bank_q[i];
      endcase
    end
  end

  always_ff @(posedge C or negedge CLR_) begin
    if (!CLR_) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NOP;
      data_q  <= '0;
      rem_q   <= '0;
      wrap_q  <= 1'b0;
      bank_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      wrap_q  <= wrap_d;
      bank_q  <= bank_d;
    end
  end

  assign Q         = bank_q;
  assign Q_        = ~bank_q;
  assign J_o       = j_drv;
  assign K_o       = k_drv;
  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_EXEC) || (state_q == ST_DONE);
  assign done      = (state_q == ST_DONE);
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_jk_seq_ctrl.sv
// tb/tb_jk_seq_ctrl.sv - scoreboard testbench for jk_seq_ctrl
module tb_jk_seq_ctrl;

  logic       C;
  logic       CLR_;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_data;
  logic [7:0] cmd_n;
  logic [3:0] Q, Q_, J_o, K_o;
  logic       busy, done, wrap;

  jk_seq_ctrl #(.WIDTH(4), .MOD(10), .CNTW(8)) dut (
    .C         (C),
    .CLR_      (CLR_),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_n     (cmd_n),
    .Q         (Q),
    .Q_        (Q_),
    .J_o       (J_o),
    .K_o       (K_o),
    .busy      (busy),
    .done      (done),
    .wrap      (wrap)
  );

  initial C = 1'b0;
  always #5 C = ~C;

  int n_cmp = 0;
  int n_err = 0;

  // {Q before step, J=K drive} per EXEC cycle; {final Q, wrap} per DONE cycle.
  logic [7:0] exec_q[$];
  logic [4:0] done_q[$];

  logic [3:0] mq;
  bit         mwrap;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_step(input logic [2:0] op, input logic [3:0] q,
                                     input logic [3:0] d, output logic [3:0] nx,
                                     output bit w);
    w  = 1'b0;
    nx = q;
    case (op)
      3'd1: nx = d;
      3'd2: nx = 4'h0;
      3'd3: nx = 4'hF;
      3'd4: if (q >= 4'd9) begin nx = 4'd0; w = 1'b1; end else nx = q + 4'd1;
      3'd5: if (q == 4'd0) begin nx = 4'd9; w = 1'b1; end else nx = q - 4'd1;
      3'd6: nx = {q[2:0], d[0]};
      3'd7: nx = {d[3], q[3:1]};
      default: nx = q;
    endcase
  endfunction

  task automatic push_expect(input logic [2:0] op, input logic [3:0] d, input logic [7:0] n);
    int cnt;
    logic [3:0] nx;
    bit w;
    cnt   = (op == 3'd1 || op == 3'd2 || op == 3'd3) ? 1 : int'(n);
    mwrap = 1'b0;
    for (int k = 0; k < cnt; k++) begin
      model_step(op, mq, d, nx, w);
      exec_q.push_back({mq, mq ^ nx});
      if (w) mwrap = 1'b1;
      mq = nx;
    end
    done_q.push_back({mq, mwrap});
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge C) begin
    logic [7:0] e;
    logic [4:0] f;
    if (CLR_) begin
      check("ready_vs_busy", cmd_ready, !busy);
      check("q_complement", {28'b0, Q ^ Q_}, 32'hF);
      if (busy && !done) begin
        if (exec_q.size() == 0) begin
          check("exec_unexpected", 1, 0);
        end else begin
          e = exec_q.pop_front();
          check("exec_q", Q, e[7:4]);
          check("exec_j", J_o, e[3:0]);
          check("exec_k", K_o, e[3:0]);
        end
      end else begin
        check("jk_quiet", {J_o, K_o}, 0);
      end
      if (done) begin
        if (done_q.size() == 0) begin
          check("done_unexpected", 1, 0);
        end else begin
          f = done_q.pop_front();
          check("done_q", Q, f[4:1]);
          check("done_wrap", wrap, f[0]);
        end
      end
    end
  end

  task automatic wait_ready();
    int budget = 0;
    @(negedge C);
    while (!cmd_ready && budget < 100) begin
      @(negedge C);
      budget++;
    end
    check("ready_wait", cmd_ready, 1);
  endtask

  task automatic send(input logic [2:0] op, input logic [3:0] d, input logic [7:0] n,
                      input bit hold);
    int budget = 0;
    wait_ready();
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    cmd_n     = n;
    push_expect(op, d, n);
    @(negedge C);
    if (!hold) cmd_valid = 1'b0;
    while (!done && budget < 300) begin
      if (hold) begin
        cmd_op   = (cmd_op == 3'd1) ? 3'd2 : 3'd1;
        cmd_data = 4'($urandom_range(0, 15));
        cmd_n    = 8'($urandom_range(1, 9));
      end
      @(negedge C);
      budget++;
    end
    check("done_seen", done, 1);
    cmd_valid = 1'b0;
    @(negedge C);
    check("ready_after_done", cmd_ready, 1);
    check("wrap_idle", wrap, mwrap);
  endtask

  initial begin
    CLR_      = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_data  = 4'h0;
    cmd_n     = 8'd0;
    mq        = 4'h0;
    mwrap     = 1'b0;

    #12;
    check("rst_q", Q, 4'h0);
    check("rst_qn", Q_, 4'hF);
    check("rst_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_jk", {J_o, K_o}, 0);
    check("rst_done_wrap", {done, wrap}, 0);
    @(negedge C);
    CLR_ = 1'b1;

    send(3'd1, 4'b0101, 8'd0, 1'b0);   // LOAD 5
    send(3'd4, 4'h0,    8'd7, 1'b0);   // UP 7: 6..9,0,1,2
    send(3'd2, 4'h0,    8'd0, 1'b0);   // CLEAR
    send(3'd5, 4'h0,    8'd2, 1'b0);   // DOWN 2: 9,8 wrap
    send(3'd6, 4'b0001, 8'd3, 1'b0);   // SHL 3 from 1000
    send(3'd3, 4'h0,    8'd0, 1'b0);   // SET
    send(3'd7, 4'b0000, 8'd2, 1'b0);   // SHR 2 in zeros
    send(3'd7, 4'b1000, 8'd1, 1'b0);   // SHR 1 in one
    send(3'd1, 4'b1100, 8'd0, 1'b0);   // LOAD 12 (>= MOD)
    send(3'd4, 4'h0,    8'd1, 1'b0);   // UP wraps 12 -> 0
    send(3'd0, 4'h0,    8'd2, 1'b0);   // NOP 2
    send(3'd4, 4'h0,    8'd0, 1'b0);   // UP n=0: no EXEC
    send(3'd5, 4'h0,    8'd3, 1'b1);   // DOWN 3 with valid held high

    // Abort mid-count.
    wait_ready();
    cmd_valid = 1'b1;
    cmd_op    = 3'd4;
    cmd_data  = 4'h0;
    cmd_n     = 8'd20;
    push_expect(3'd4, 4'h0, 8'd20);
    @(negedge C);
    cmd_valid = 1'b0;
    repeat (3) @(negedge C);
    #2 CLR_ = 1'b0;
    #1;
    check("abort_q", Q, 4'h0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_wrap", wrap, 0);
    check("abort_ready", cmd_ready, 1);
    exec_q.delete();
    done_q.delete();
    mq    = 4'h0;
    mwrap = 1'b0;
    @(negedge C);
    CLR_ = 1'b1;
    repeat (3) @(negedge C);

    send(3'd1, 4'b0011, 8'd0, 1'b0);   // LOAD 3 after abort
    send(3'd4, 4'h0,    8'd2, 1'b0);   // UP 2

    repeat (2) @(negedge C);
    check("exec_left", exec_q.size(), 0);
    check("done_left", done_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
